// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor (a - b), one bit per clock, LSB first.
// A single full-subtractor cell (two half-subtractor stages) and a borrow flop do
// the arithmetic; the minuend shift register doubles as the result register.
// Optional build macro: SERIAL_SUB_CLAMP_EN -- when defined, a final borrow forces
// diff to zero (saturating subtract); borrow still reports 1.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;      // minuend bits shift out at [0], result bits shift in at MSB
    logic [WIDTH-1:0] sh_b;     // subtrahend shift register
    logic [CW-1:0]    cnt;      // index of the bit processed this RUN cycle
    logic             bin;      // borrow carried into the current bit

    logic             hs1_d;
    logic             hs1_b;
    logic             hs2_b;
    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_final;

    // Full subtractor built from two half-subtractor stages on the current LSBs
    always_comb begin
        hs1_d     = acc[0] ^ sh_b[0];
        hs1_b     = ~acc[0] & sh_b[0];
        fs_d      = hs1_d ^ bin;
        hs2_b     = ~hs1_d & bin;
        fs_bout   = hs1_b | hs2_b;
        res_final = {fs_d, acc[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= a;
                        sh_b  <= b;
                        cnt   <= '0;
                        bin   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= res_final;
                    sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                    bin  <= fs_bout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        borrow <= fs_bout;
`ifdef SERIAL_SUB_CLAMP_EN
                        diff   <= fs_bout ? '0 : res_final;
`else
                        diff   <= res_final;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
